fp_mul_seq: RTL and testbench

- Multi-cycle sequencer for the single-precision FP multiplier datapath: Booth mantissa product, then normalise, then round.
- Accepts one operand pair per transaction over a valid/ready handshake and classifies special operands.
- Drives an iterative radix-4 Booth step unit, then normalises, rounds per `r_mode` and returns `fp_Z` with `ovrf`/`udrf` flags.
- Sits between the FPU issue logic and the result writeback path.

---
 rtl/fp_mul_pkg.sv | 47 ++++
 rtl/fp_mul_booth_iter.sv | 58 +++++
 rtl/fp_mul_seq.sv | 189 ++++++++++++++++++
 tb/tb_fp_mul_seq.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_mul_pkg.sv
// Shared types and constants for the sequential single-precision multiplier.
package fp_mul_pkg;

  localparam int SGN_W = 1;
  localparam int EXP_W = 8;
  localparam int FRC_W = 23;

  localparam int          EXP_BIAS = 127;
  localparam int          EXP_MAX  = 255;
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;
  localparam logic [30:0] MAXF     = 31'h7F7F_FFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_MUL,
    S_NORM,
    S_ROUND,
    S_DONE
  } state_t;

  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RTZ = 3'b001,
    RM_RDN = 3'b010,
    RM_RUP = 3'b011,
    RM_RMM = 3'b100
  } rmode_t;

  typedef struct packed {
    logic [SGN_W-1:0] sgn;
    logic [EXP_W-1:0] exp;
    logic [FRC_W-1:0] frc;
  } fp32_t;

  // Reserved encodings fall back to round-to-nearest-even.
  function automatic rmode_t to_rmode(input logic [2:0] m);
    case (m)
      3'b001:  return RM_RTZ;
      3'b010:  return RM_RDN;
      3'b011:  return RM_RUP;
      3'b100:  return RM_RMM;
      default: return RM_RNE;
    endcase
  endfunction

endpackage

// File: rtl/fp_mul_booth_iter.sv
// Iterative radix-4 Booth multiplier: one recoded digit of the multiplier per step.
// The accumulator is kept modulo 2^48; intermediate partial sums may go
// negative, but the final unsigned 24x24 product always fits in 48 bits.
module fp_mul_booth_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [23:0] mcand,
  input  logic [23:0] mplier,
  output logic [47:0] product
);

  logic [47:0] acc;
  logic [47:0] m_sh;    // multiplicand pre-shifted to the current digit weight
  logic [25:0] q;       // zero-extended multiplier, consumed 2 bits per step
  logic        q_prev;  // bit just below the current Booth group
  logic [2:0]  grp;
  logic [47:0] pp;

  assign grp     = {q[1], q[0], q_prev};
  assign product = acc;

  // Recode the current bit group into a partial product of 0, +-M or +-2M.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    pp = '0;
    unique case (grp)
      3'b001, 3'b010: pp = m_sh;
      3'b011:         pp = m_sh << 1;
      3'b100:         pp = ~(m_sh << 1) + 48'd1;
      3'b101, 3'b110: pp = ~m_sh + 48'd1;
      default:        pp = '0;
    endcase
  end

  // Load operands, then accumulate one partial product and advance by 2 bits per step.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    if (rst) begin
      acc    <= '0;
      m_sh   <= '0;
      q      <= '0;
      q_prev <= 1'b0;
    end else if (load) begin
      acc    <= '0;
      m_sh   <= {24'b0, mcand};
      q      <= {2'b0, mplier};
      q_prev <= 1'b0;
    end else if (step) begin
      acc    <= acc + pp;
      m_sh   <= m_sh << 2;
      q      <= {2'b00, q[25:2]};
      q_prev <= q[1];
    end
  end

endmodule

// File: rtl/fp_mul_seq.sv
// Sequencer for the single-precision multiplier: classify operands, run the
// Booth unit, normalise, round and hold the result until it is accepted.
module fp_mul_seq
  import fp_mul_pkg::*;
#(
  parameter int MUL_STEPS = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] fp_X,
  input  logic [31:0] fp_Y,
  input  logic [2:0]  r_mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] fp_Z,
  output logic        ovrf,
  output logic        udrf,
  output logic        busy
);

  state_t             state;
  fp32_t              x_q, y_q;
  rmode_t             mode_q;
  logic               sign_z;
  logic signed [9:0]  e_q;
  logic [25:0]        f_q;
  logic [3:0]         cnt;
  logic [47:0]        product;

  // Operand classification; subnormals count as zero.
  logic x_zero, x_inf, x_nan, y_zero, y_inf, y_nan, sign_c;
  assign x_zero = (x_q.exp == '0);
  assign y_zero = (y_q.exp == '0);
  assign x_inf  = (x_q.exp == 8'hFF) && (x_q.frc == '0);
  assign y_inf  = (y_q.exp == 8'hFF) && (y_q.frc == '0);
  assign x_nan  = (x_q.exp == 8'hFF) && (x_q.frc != '0);
  assign y_nan  = (y_q.exp == 8'hFF) && (y_q.frc != '0);
  assign sign_c = x_q.sgn ^ y_q.sgn;

  fp_mul_booth_iter u_booth (
    .clk     (clk),
    .rst     (rst),
    .load    (state == S_CHECK),
    .step    (state == S_MUL),
    .mcand   ({1'b1, x_q.frc}),
    .mplier  ({1'b1, y_q.frc}),
    .product (product)
  );

  // Resolve special operands to their fixed results.
  logic        special;
  logic [31:0] special_z;
  always_comb begin
    special   = 1'b1;
    special_z = QNAN;
    if (x_nan || y_nan) begin
      special_z = QNAN;
    end else if ((x_inf && y_zero) || (y_inf && x_zero)) begin
      special_z = QNAN;
    end else if (x_inf || y_inf) begin
      special_z = {sign_c, 8'hFF, 23'b0};
    end else if (x_zero || y_zero) begin
      special_z = {sign_c, 31'b0};
    end else begin
      special = 1'b0;
    end
  end

  // Normalise the product to 26 bits: 24-bit significand, guard, and sticky.
  logic        norm_n;
  logic [25:0] f_next;
  always_comb begin
    norm_n = product[47];
    if (norm_n) f_next = {product[47:23], product[22] | (|product[21:0])};
    else        f_next = {product[46:22], product[21] | (|product[20:0])};
  end

  // Round the significand and pack the result, handling overflow and underflow.
  logic [23:0]       sig;
  logic              guard, sticky, inexact, round_inc, norm_r, ovf_inf;
  logic [24:0]       sum;
  logic [22:0]       frc_r;
  logic signed [9:0] e_r;
  logic              ovf_r, udf_r;
  logic [31:0]       round_z;
  always_comb begin
    sig     = f_q[25:2];
    guard   = f_q[1];
    sticky  = f_q[0];
    inexact = guard | sticky;
    case (mode_q)
      RM_RTZ:  round_inc = 1'b0;
      RM_RDN:  round_inc = sign_z & inexact;
      RM_RUP:  round_inc = ~sign_z & inexact;
      RM_RMM:  round_inc = guard;
      default: round_inc = guard & (sticky | sig[0]);
    endcase
    sum    = {1'b0, sig} + {24'b0, round_inc};
    norm_r = sum[24];
    frc_r  = norm_r ? sum[23:1] : sum[22:0];
    e_r    = e_q + $signed({9'b0, norm_r});
    ovf_r  = (e_r >= $signed(10'(EXP_MAX)));
    udf_r  = (e_r <= 10'sd0);
    case (mode_q)
      RM_RTZ:  ovf_inf = 1'b0;
      RM_RDN:  ovf_inf = sign_z;
      RM_RUP:  ovf_inf = ~sign_z;
      default: ovf_inf = 1'b1;
    endcase
    if (ovf_r)      round_z = ovf_inf ? {sign_z, 8'hFF, 23'b0} : {sign_z, MAXF};
    else if (udf_r) round_z = {sign_z, 31'b0};
    else            round_z = {sign_z, e_r[7:0], frc_r};
  end

  // Transaction FSM with registered handshake, status and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      fp_Z      <= '0;
      ovrf      <= 1'b0;
      udrf      <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      mode_q    <= RM_RNE;
      sign_z    <= 1'b0;
      e_q       <= '0;
      f_q       <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            x_q      <= fp_X;
            y_q      <= fp_Y;
            mode_q   <= to_rmode(r_mode);
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= S_CHECK;
          end
        end
        S_CHECK: begin
          sign_z <= sign_c;
          e_q    <= $signed(10'(x_q.exp) + 10'(y_q.exp) - 10'(EXP_BIAS));
          cnt    <= '0;
          if (special) begin
            fp_Z      <= special_z;
            ovrf      <= 1'b0;
            udrf      <= 1'b0;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
            state <= S_MUL;
          end
        end
        S_MUL: begin
          cnt <= cnt + 4'd1;
          if (cnt == 4'(MUL_STEPS - 1)) state <= S_NORM;
        end
        S_NORM: begin
          f_q   <= f_next;
          e_q   <= e_q + $signed({9'b0, norm_n});
          state <= S_ROUND;
        end
        S_ROUND: begin
          fp_Z      <= round_z;
          ovrf      <= ovf_r;
          udrf      <= udf_r;
          out_valid <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mul_seq.sv
// Scoreboard bench for fp_mul_seq: directed vectors plus random operands
// checked against a plain-arithmetic reference model.
module tb_fp_mul_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] fp_X = '0;
  logic [31:0] fp_Y = '0;
  logic [2:0]  r_mode = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] fp_Z;
  logic        ovrf, udrf, busy;

  always #5 clk = ~clk;

  fp_mul_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fp_X      (fp_X),
    .fp_Y      (fp_Y),
    .r_mode    (r_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fp_Z      (fp_Z),
    .ovrf      (ovrf),
    .udrf      (udrf),
    .busy      (busy)
  );

  typedef struct {
    logic [31:0] z;
    logic        ovf;
    logic        udf;
    int          lat;      // edge index of DONE entry, accept edge counted as 1
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   ready_mode = 1;   // 0: hold off, 1: always ready, 2: random
  bit   seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] z, input logic ovf, input logic udf, input int lat);
    exp_t e;
    e.z = z; e.ovf = ovf; e.udf = udf; e.lat = lat; e.acc_cyc = 0;
    return e;
  endfunction

  // Reference: exact integer product, then round by comparing the discarded
  // remainder against half an ulp.
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic [2:0] m);
    exp_t            r;
    logic            s;
    int              ex, ey, e, msb, sh;
    logic [63:0]     p, keep, rem, half;
    logic [2:0]      mm;
    bit              xz, xi, xn, yz, yi, yn, inc, to_inf;
    s  = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    xz = (ex == 0); xi = (ex == 255) && (x[22:0] == 0); xn = (ex == 255) && (x[22:0] != 0);
    yz = (ey == 0); yi = (ey == 255) && (y[22:0] == 0); yn = (ey == 255) && (y[22:0] != 0);
    r = mk(32'h0, 1'b0, 1'b0, 2);
    if (xn || yn)                   begin r.z = 32'h7FC00000; return r; end
    if ((xi && yz) || (yi && xz))   begin r.z = 32'h7FC00000; return r; end
    if (xi || yi)                   begin r.z = {s, 8'hFF, 23'h0}; return r; end
    if (xz || yz)                   begin r.z = {s, 31'h0}; return r; end
    r.lat = 17;
    p = 64'({1'b1, x[22:0]}) * 64'({1'b1, y[22:0]});
    msb = 0;
    for (int i = 0; i < 64; i++) if (p[i]) msb = i;
    sh   = msb - 23;
    keep = p >> sh;
    rem  = p & ((64'd1 << sh) - 64'd1);
    half = 64'd1 << (sh - 1);
    e    = ex + ey - 127 + (msb - 46);
    mm   = (m > 3'd4) ? 3'd0 : m;
    case (mm)
      3'd0:    inc = (rem > half) || ((rem == half) && keep[0]);
      3'd1:    inc = 1'b0;
      3'd2:    inc = s && (rem != 0);
      3'd3:    inc = !s && (rem != 0);
      default: inc = (rem >= half);
    endcase
    keep = keep + 64'(inc);
    if (keep == (64'd1 << 24)) begin keep = keep >> 1; e++; end
    if (e >= 255) begin
      r.ovf  = 1'b1;
      to_inf = (mm == 3'd0) || (mm == 3'd4) || ((mm == 3'd2) && s) || ((mm == 3'd3) && !s);
      r.z    = to_inf ? {s, 8'hFF, 23'h0} : {s, 31'h7F7FFFFF};
    end else if (e <= 0) begin
      r.udf = 1'b1;
      r.z   = {s, 31'h0};
    end else begin
      r.z = {s, 8'(e), keep[22:0]};
    end
    return r;
  endfunction

  function automatic logic [31:0] gen_op();
    logic [31:0] v;
    int          k;
    k = $urandom_range(0, 19);
    v = $urandom;
    if (k == 0)       v[30:23] = 8'h00;
    else if (k == 1)  begin v[30:23] = 8'hFF; v[22:0] = '0; end
    else if (k == 2)  v[30:23] = 8'hFF;
    else if (k == 3)  begin v[30:23] = 8'($urandom_range(100, 154)); v[22:4] = '1; end
    else if (k < 12)  v[30:23] = 8'($urandom_range(100, 154));
    else              v[30:23] = 8'($urandom_range(1, 254));
    return v;
  endfunction

  // Out_ready is driven just after each rising edge.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Monitor: compare every cycle a result is presented, pop on handshake.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        check("spurious_out_valid", {31'b0, out_valid}, 32'd0);
      end else begin
        if (!seen) begin
          seen = 1'b1;
          check("latency", 32'(cyc - sb[0].acc_cyc + 1), 32'(sb[0].lat));
        end
        check("fp_Z", fp_Z, sb[0].z);
        check("ovrf", {31'b0, ovrf}, {31'b0, sb[0].ovf});
        check("udrf", {31'b0, udrf}, {31'b0, sb[0].udf});
        if (out_ready) begin
          void'(sb.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [2:0] m, input exp_t e);
    int w = 0;
    @(negedge clk);
    fp_X = x; fp_Y = y; r_mode = m; in_valid = 1'b1;
    while (!in_ready && w < 100) begin @(negedge clk); w++; end
    if (!in_ready) begin
      check("accept_timeout", {31'b0, in_ready}, 32'd1);
      in_valid = 1'b0;
      return;
    end
    e.acc_cyc = cyc + 1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    fp_X = $urandom; fp_Y = $urandom; r_mode = 3'($urandom);
  endtask

  task automatic drain();
    int w = 0;
    while (sb.size() != 0 && w < 400) begin @(negedge clk); w++; end
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d results pending", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] x, y;
    logic [2:0]  m;
    int          w;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",  {31'b0, in_ready},  32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_fp_Z",      fp_Z,               32'd0);
    check("rst_busy",      {31'b0, busy},      32'd0);
    check("rst_ovrf",      {31'b0, ovrf},      32'd0);
    check("rst_udrf",      {31'b0, udrf},      32'd0);
    rst = 1'b0;

    // Directed vectors with hand-derived results.
    send(32'h40400000, 32'h40400000, 3'b001, mk(32'h41100000, 0, 0, 17));
    send(32'h00000000, 32'h40A00000, 3'b000, mk(32'h00000000, 0, 0, 2));
    send(32'h802DF854, 32'h3F800000, 3'b000, mk(32'h80000000, 0, 0, 2));
    send(32'h7F800000, 32'h00000000, 3'b000, mk(32'h7FC00000, 0, 0, 2));
    send(32'h7F000000, 32'h40000000, 3'b000, mk(32'h7F800000, 1, 0, 17));
    send(32'h7F000000, 32'h40000000, 3'b001, mk(32'h7F7FFFFF, 1, 0, 17));
    send(32'hFF000000, 32'h40000000, 3'b011, mk(32'hFF7FFFFF, 1, 0, 17));
    send(32'h00800000, 32'h00800000, 3'b000, mk(32'h00000000, 0, 1, 17));
    send(32'h3F800001, 32'h3F800001, 3'b011, mk(32'h3F800003, 0, 0, 17));
    send(32'h3F800001, 32'h3F800001, 3'b010, mk(32'h3F800002, 0, 0, 17));
    send(32'h3F800001, 32'h3F800001, 3'b101, mk(32'h3F800002, 0, 0, 17));
    send(32'h7FC12345, 32'h3F800000, 3'b000, mk(32'h7FC00000, 0, 0, 2));
    send(32'hFF800000, 32'h40000000, 3'b000, mk(32'h7F800000 | 32'h80000000, 0, 0, 2));
    drain();

    // Backpressure: result must hold while out_ready is low.
    ready_mode = 0;
    @(posedge clk);
    send(32'h40400000, 32'h40400000, 3'b001, mk(32'h41100000, 0, 0, 17));
    w = 0;
    while (!out_valid && w < 40) begin @(negedge clk); w++; end
    check("bp_out_valid", {31'b0, out_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("bp_fp_Z",     fp_Z,              32'h41100000);
      check("bp_in_ready", {31'b0, in_ready}, 32'd0);
      check("bp_busy",     {31'b0, busy},     32'd1);
      if (i == 1) begin in_valid = 1'b1; fp_X = 32'h3F800000; fp_Y = 32'h3F800000; end
      if (i == 2) in_valid = 1'b0;
      @(negedge clk);
    end
    ready_mode = 1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("release_in_ready",  {31'b0, in_ready},  32'd1);
    check("release_out_valid", {31'b0, out_valid}, 32'd0);
    check("release_busy",      {31'b0, busy},      32'd0);
    check("release_fp_Z_hold", fp_Z,               32'h41100000);
    repeat (25) @(negedge clk);
    check("ignored_pulse_idle", {31'b0, in_ready}, 32'd1);

    // Reset during the sixth Booth step aborts the transaction.
    send(32'h40400000, 32'h40400000, 3'b001, mk(32'h41100000, 0, 0, 17));
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    seen = 1'b0;
    @(negedge clk);
    check("abort_in_ready",  {31'b0, in_ready},  32'd1);
    check("abort_out_valid", {31'b0, out_valid}, 32'd0);
    check("abort_fp_Z",      fp_Z,               32'd0);
    check("abort_busy",      {31'b0, busy},      32'd0);
    repeat (20) @(negedge clk);
    send(32'h40400000, 32'h40400000, 3'b001, mk(32'h41100000, 0, 0, 17));
    drain();

    // Random operands and modes with random backpressure.
    ready_mode = 2;
    for (int n = 0; n < 250; n++) begin
      x = gen_op();
      y = gen_op();
      m = 3'($urandom_range(0, 7));
      send(x, y, m, model(x, y, m));
    end
    drain();
    ready_mode = 1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
